// File: rtl/ibex_rf_l2_port_sched.sv
// L2 register-SRAM port scheduler: serialises operand-A/B miss fills and buffered write-back
// drains onto one SRAM port. Define IBEX_RF_L2_PERF_EN to build the perf_* counters.
module ibex_rf_l2_port_sched #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 5,
   parameter int unsigned WBufDepth = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rd_a_req_i,
   input  logic [AddrWidth-1:0] rd_a_addr_i,
   input  logic                 rd_b_req_i,
   input  logic [AddrWidth-1:0] rd_b_addr_i,
   input  logic                 wr_req_i,
   input  logic [AddrWidth-1:0] wr_addr_i,
   input  logic [DataWidth-1:0] wr_data_i,
   output logic                 wr_ready_o,
   output logic                 rd_valid_o,
   output logic [DataWidth-1:0] rd_a_data_o,
   output logic [DataWidth-1:0] rd_b_data_o,
   output logic                 stall_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic                 sram_we_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   input  logic [DataWidth-1:0] sram_rdata_i,
   output logic [31:0]          perf_miss_o,
   output logic [31:0]          perf_fwd_o,
   output logic [31:0]          perf_stall_o
);

   localparam int unsigned PtrW = (WBufDepth > 1) ? $clog2(WBufDepth) : 1;
   localparam int unsigned CntW = $clog2(WBufDepth + 1);
   localparam logic [CntW-1:0] DepthCnt = CntW'(WBufDepth);
   localparam logic [PtrW-1:0] LastPtr  = PtrW'(WBufDepth - 1);

   typedef enum logic [1:0] {IDLE, RDB, CAP, RSP} state_e;

   state_e                 state_q, state_d;
   logic                   init_done_q;
   logic                   cap_b_q, cap_b_d;
   logic [DataWidth-1:0]   rd_a_q, rd_a_d, rd_b_q, rd_b_d;
   logic [PtrW-1:0]        head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [AddrWidth-1:0]   buf_addr_q [WBufDepth];
   logic [DataWidth-1:0]   buf_data_q [WBufDepth];

   logic                   wr_accept, enq, drain, buf_full, buf_empty;
   logic                   a_hit, b_hit, a_sram, b_sram, rd_any;
   logic [DataWidth-1:0]   a_fwd, b_fwd;
   logic                   idle_go, idle_rd_a, idle_rd_b, idle_fwd;
   logic                   cap_a_idle, cap_b_idle;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   assign buf_full   = (cnt_q == DepthCnt);
   assign buf_empty  = (cnt_q == '0);
   // Held low for the first cycle after reset release so every output reads 0 in reset.
   assign wr_ready_o = init_done_q & ~buf_full;
   assign wr_accept  = wr_req_i & wr_ready_o;
   assign enq        = wr_accept & (wr_addr_i != '0);

   // Newest-match search: walk entries oldest to newest so later hits override earlier ones.
   always_comb begin
      logic [PtrW-1:0] idx;
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      a_hit = 1'b0;
      b_hit = 1'b0;
      a_fwd = '0;
      b_fwd = '0;
      idx   = head_q;
      for (int i = 0; i < int'(WBufDepth); i++) begin
         if (CntW'(i) < cnt_q) begin
            if (buf_addr_q[idx] == rd_a_addr_i) begin
               a_hit = 1'b1;
               a_fwd = buf_data_q[idx];
            end
            if (buf_addr_q[idx] == rd_b_addr_i) begin
               b_hit = 1'b1;
               b_fwd = buf_data_q[idx];
            end
         end
         idx = ptr_inc(idx);
      end
   end

   assign a_sram = rd_a_req_i & (rd_a_addr_i != '0) & ~a_hit;
   assign b_sram = rd_b_req_i & (rd_b_addr_i != '0) & ~b_hit;
   assign rd_any = rd_a_req_i | rd_b_req_i;

   // IDLE decision: a same-cycle write acceptance defers reads by one cycle for RAW ordering.
   assign idle_go    = (state_q == IDLE) & init_done_q & ~wr_accept & ~buf_full;
   assign idle_rd_a  = idle_go & a_sram;
   assign idle_rd_b  = idle_go & ~a_sram & b_sram;
   assign idle_fwd   = idle_go & ~a_sram & ~b_sram & rd_any;
   assign cap_a_idle = idle_go & rd_a_req_i & ~a_sram;
   assign cap_b_idle = idle_go & rd_b_req_i & ~b_sram;

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q     <= IDLE;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_done_q <= 1'b1;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (idle_rd_a)      state_d = b_sram ? RDB : CAP;
            else if (idle_rd_b) state_d = CAP;
            else if (idle_fwd)  state_d = RSP;
         end
         RDB:     state_d = CAP;
         CAP:     state_d = RSP;
         RSP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: the SRAM port carries a read address, a drain, or nothing
   always_comb begin
      drain        = 1'b0;
      rd_valid_o   = 1'b0;
      sram_addr_o  = '0;
      sram_we_o    = 1'b0;
      sram_wdata_o = '0;
      unique case (state_q)
         IDLE: begin
            if (idle_rd_a)      sram_addr_o = rd_a_addr_i;
            else if (idle_rd_b) sram_addr_o = rd_b_addr_i;
            drain = init_done_q & ~wr_accept & ~buf_empty & ~(idle_rd_a | idle_rd_b | idle_fwd);
         end
         RDB: sram_addr_o = rd_b_addr_i;
         CAP: drain = ~buf_empty;
         RSP: begin
            drain      = ~buf_empty;
            rd_valid_o = 1'b1;
         end
         default: ;
      endcase
      if (drain) begin
         sram_addr_o  = buf_addr_q[head_q];
         sram_we_o    = 1'b1;
         sram_wdata_o = buf_data_q[head_q];
      end
   end

   assign stall_o = (rd_any & ~rd_valid_o) | (wr_req_i & ~wr_ready_o);

   // Operand capture; cap_b_q records which operand the CAP cycle receives from the SRAM
   always_comb begin
      rd_a_d  = rd_a_q;
      rd_b_d  = rd_b_q;
      cap_b_d = cap_b_q;
      if (cap_a_idle) rd_a_d = a_fwd;
      if (cap_b_idle) rd_b_d = b_fwd;
      if (idle_rd_a | idle_rd_b) cap_b_d = idle_rd_b | b_sram;
      if (state_q == RDB) rd_a_d = sram_rdata_i;
      if (state_q == CAP) begin
         if (cap_b_q) rd_b_d = sram_rdata_i;
         else         rd_a_d = sram_rdata_i;
      end
   end

   always_comb begin
      head_d = drain ? ptr_inc(head_q) : head_q;
      tail_d = enq ? ptr_inc(tail_q) : tail_q;
      cnt_d  = cnt_q + CntW'(enq) - CntW'(drain);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_a_q  <= '0;
         rd_b_q  <= '0;
         cap_b_q <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
      end else begin
         rd_a_q  <= rd_a_d;
         rd_b_q  <= rd_b_d;
         cap_b_q <= cap_b_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: buffer storage carries no reset; cnt_q alone decides which entries are live.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         buf_addr_q[tail_q] <= wr_addr_i;
         buf_data_q[tail_q] <= wr_data_i;
      end
   end

   assign rd_a_data_o = rd_a_q;
   assign rd_b_data_o = rd_b_q;

`ifdef IBEX_RF_L2_PERF_EN
   logic        sram_rd;
   logic [1:0]  fwd_inc;
   logic [31:0] perf_miss_q, perf_miss_d, perf_fwd_q, perf_fwd_d, perf_stall_q, perf_stall_d;

   function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] inc);
      logic [32:0] sum;
      sum = {1'b0, v} + {31'b0, inc};
      return sum[32] ? '1 : sum[31:0];
   endfunction

   assign sram_rd = idle_rd_a | idle_rd_b | (state_q == RDB);
   assign fwd_inc = {1'b0, cap_a_idle & a_hit} + {1'b0, cap_b_idle & b_hit};

   always_comb begin
      perf_miss_d  = sat_add(perf_miss_q, {1'b0, sram_rd});
      perf_fwd_d   = sat_add(perf_fwd_q, fwd_inc);
      perf_stall_d = sat_add(perf_stall_q, {1'b0, stall_o});
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_miss_q  <= '0;
         perf_fwd_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_miss_q  <= perf_miss_d;
         perf_fwd_q   <= perf_fwd_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_miss_o  = perf_miss_q;
   assign perf_fwd_o   = perf_fwd_q;
   assign perf_stall_o = perf_stall_q;
`else
   assign perf_miss_o  = '0;
   assign perf_fwd_o   = '0;
   assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_ibex_rf_l2_port_sched.sv
// Self-checking bench for ibex_rf_l2_port_sched: behavioural SRAM, reference register file,
// and a scoreboard of expected operand pairs popped on every rd_valid_o pulse.
module tb_ibex_rf_l2_port_sched;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        rd_a_req_i = 1'b0, rd_b_req_i = 1'b0, wr_req_i = 1'b0;
   logic [4:0]  rd_a_addr_i = '0, rd_b_addr_i = '0, wr_addr_i = '0;
   logic [31:0] wr_data_i = '0;
   logic        wr_ready_o, rd_valid_o, stall_o, sram_we_o;
   logic [31:0] rd_a_data_o, rd_b_data_o, sram_wdata_o, sram_rdata_i;
   logic [4:0]  sram_addr_o;
   logic [31:0] perf_miss_o, perf_fwd_o, perf_stall_o;

   ibex_rf_l2_port_sched dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .rd_a_req_i(rd_a_req_i), .rd_a_addr_i(rd_a_addr_i),
      .rd_b_req_i(rd_b_req_i), .rd_b_addr_i(rd_b_addr_i),
      .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .wr_ready_o(wr_ready_o), .rd_valid_o(rd_valid_o),
      .rd_a_data_o(rd_a_data_o), .rd_b_data_o(rd_b_data_o), .stall_o(stall_o),
      .sram_addr_o(sram_addr_o), .sram_we_o(sram_we_o), .sram_wdata_o(sram_wdata_o),
      .sram_rdata_i(sram_rdata_i),
      .perf_miss_o(perf_miss_o), .perf_fwd_o(perf_fwd_o), .perf_stall_o(perf_stall_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        a_req;
      logic        b_req;
      logic [31:0] a_data;
      logic [31:0] b_data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem [32];
   logic [31:0] ref_rf [32];
   logic        do_init = 1'b1;
   logic [4:0]  addr_log [8];
   int          n_checks = 0, n_pass = 0, stall_gap = 0;

   function automatic logic [31:0] init_val(input int i);
      return (i == 5) ? 32'h0000_1234 : (32'hA500_0000 | 32'(i));
   endfunction

   // Behavioural SRAM: read data valid the cycle after the address
   always @(posedge clk_i) begin
      if (do_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
      end else if (sram_we_o) begin
         mem[sram_addr_o] <= sram_wdata_o;
      end
      sram_rdata_i <= mem[sram_addr_o];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic sb_compare();
      exp_t e;
      check("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.a_req) check("rd_a_data", rd_a_data_o, e.a_data);
         if (e.b_req) check("rd_b_data", rd_b_data_o, e.b_data);
      end
   endtask

   task automatic drive_rd(input logic a_req, input logic [4:0] a_addr,
                           input logic b_req, input logic [4:0] b_addr);
      exp_t e;
      rd_a_req_i = a_req; rd_a_addr_i = a_addr;
      rd_b_req_i = b_req; rd_b_addr_i = b_addr;
      e.a_req  = a_req;
      e.b_req  = b_req;
      e.a_data = (a_addr == 0) ? 32'h0 : ref_rf[a_addr];
      e.b_data = (b_addr == 0) ? 32'h0 : ref_rf[b_addr];
      sb.push_back(e);
   endtask

   // Caller has just driven at a negedge; cycle 0 is that cycle.
   task automatic wait_valid(input int budget, output int lat, output int nreads);
      lat = -1; nreads = 0; stall_gap = 0;
      for (int c = 0; c < budget; c++) begin
         if (c > 0) @(negedge clk_i);
         #1;
         if (c < 8) addr_log[c] = sram_addr_o;
         if (!sram_we_o && sram_addr_o != '0) nreads++;
         if (rd_valid_o) begin
            lat = c;
            sb_compare();
            break;
         end
         if (!stall_o) stall_gap++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_i);
         rd_a_req_i = 1'b0; rd_b_req_i = 1'b0; wr_req_i = 1'b0;
      end
   endtask

   task automatic rd_txn(input string tag, input logic a_req, input logic [4:0] a_addr,
                         input logic b_req, input logic [4:0] b_addr,
                         input int exp_lat, input int exp_reads);
      int lat, nr;
      @(negedge clk_i);
      wr_req_i = 1'b0;
      drive_rd(a_req, a_addr, b_req, b_addr);
      wait_valid(12, lat, nr);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_sram_reads"}, 32'(nr), 32'(exp_reads));
      check({tag, "_stall"}, 32'(stall_gap), 0);
      idle(1);
   endtask

   task automatic wr_one(input logic [4:0] addr, input logic [31:0] data);
      logic acc;
      acc = 1'b0;
      @(negedge clk_i);
      rd_a_req_i = 1'b0; rd_b_req_i = 1'b0;
      wr_req_i = 1'b1; wr_addr_i = addr; wr_data_i = data;
      for (int c = 0; c < 8 && !acc; c++) begin
         if (c > 0) @(negedge clk_i);
         #1;
         if (wr_ready_o) acc = 1'b1;
      end
      check("wr_accept", 32'(acc), 1);
      if (acc && addr != 0) ref_rf[addr] = data;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_ready"}, 32'(wr_ready_o), 0);
      check({tag, "_rd_valid"}, 32'(rd_valid_o), 0);
      check({tag, "_stall"}, 32'(stall_o), 0);
      check({tag, "_sram_we"}, 32'(sram_we_o), 0);
      check({tag, "_sram_addr"}, 32'(sram_addr_o), 0);
      check({tag, "_rd_a"}, rd_a_data_o, 0);
      check({tag, "_rd_b"}, rd_b_data_o, 0);
      check({tag, "_perf"}, perf_miss_o | perf_fwd_o | perf_stall_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, nr, we_cnt;
      logic acc;
      for (int i = 0; i < 32; i++) ref_rf[i] = init_val(i);

      // Reset and release
      repeat (3) @(posedge clk_i);
      do_init = 1'b0;
      @(negedge clk_i); #1;
      check_reset_outputs("reset");
      rst_ni = 1'b1;
      #1 check("ready_after_release", 32'(wr_ready_o), 0);
      @(negedge clk_i); #1;
      check("ready_next_cycle", 32'(wr_ready_o), 1);

      // 1) A-only SRAM miss
      rd_txn("t1", 1'b1, 5'd5, 1'b0, 5'd0, 2, 1);
      check("t1_addr_t0", 32'(addr_log[0]), 5);

      // 2) A and B both miss
      rd_txn("t2", 1'b1, 5'd3, 1'b1, 5'd7, 3, 2);
      check("t2_addr_t0", 32'(addr_log[0]), 3);
      check("t2_addr_t1", 32'(addr_log[1]), 7);

      // 3) Forward buffered write before it drains
      wr_one(5'd9, 32'h0000_DEAD);
      rd_txn("t3", 1'b1, 5'd9, 1'b0, 5'd0, 1, 0);
      idle(3);
      check("t3_drained", mem[9], 32'h0000_DEAD);

      // 5) x0 reads and x0 write
      rd_txn("t5", 1'b1, 5'd0, 1'b1, 5'd0, 1, 0);
      wr_one(5'd0, 32'hFFFF_FFFF);
      we_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         wr_req_i = 1'b0;
         #1 if (sram_we_o) we_cnt++;
      end
      check("t5_x0_no_write", 32'(we_cnt), 0);

      // 4) Three back-to-back writes against pending A/B misses, depth 2
      @(negedge clk_i);
      wr_req_i = 1'b1; wr_addr_i = 5'd10; wr_data_i = 32'h111;
      drive_rd(1'b1, 5'd3, 1'b1, 5'd7);
      #1;
      check("t4_w1_ready", 32'(wr_ready_o), 1);
      check("t4_w1_deferred", 32'(sram_addr_o), 0);
      ref_rf[10] = 32'h111;
      @(negedge clk_i);
      wr_addr_i = 5'd11; wr_data_i = 32'h222;
      #1;
      check("t4_w2_ready", 32'(wr_ready_o), 1);
      check("t4_w2_deferred", 32'(sram_addr_o), 0);
      ref_rf[11] = 32'h222;
      @(negedge clk_i);
      wr_addr_i = 5'd10; wr_data_i = 32'h333;
      #1;
      check("t4_w3_ready", 32'(wr_ready_o), 0);
      check("t4_drain_we", 32'(sram_we_o), 1);
      check("t4_drain_addr", 32'(sram_addr_o), 10);
      check("t4_drain_data", sram_wdata_o, 32'h111);
      acc = 1'b0;
      for (int c = 0; c < 8 && !acc; c++) begin
         @(negedge clk_i); #1;
         if (wr_ready_o) acc = 1'b1;
      end
      check("t4_w3_accept", 32'(acc), 1);
      ref_rf[10] = 32'h333;
      @(negedge clk_i);
      wr_req_i = 1'b0;
      wait_valid(16, lat, nr);
      check("t4_valid_seen", 32'(lat >= 0), 1);
      idle(6);
      check("t4_mem10", mem[10], ref_rf[10]);
      check("t4_mem11", mem[11], ref_rf[11]);

      // 6) Reset while in RDB with buffered writes
      @(negedge clk_i);
      wr_req_i = 1'b1; wr_addr_i = 5'd20; wr_data_i = 32'h5555;
      #1 check("t6_w1_ready", 32'(wr_ready_o), 1);
      @(negedge clk_i);
      wr_req_i = 1'b0;
      drive_rd(1'b1, 5'd3, 1'b1, 5'd7);
      #1 check("t6_rd_a_issue", 32'(sram_addr_o), 3);
      @(negedge clk_i);
      wr_req_i = 1'b1; wr_addr_i = 5'd21; wr_data_i = 32'h6666;
      #1 check("t6_rdb_addr", 32'(sram_addr_o), 7);
      #1;
      rst_ni = 1'b0;
      rd_a_req_i = 1'b0; rd_b_req_i = 1'b0; wr_req_i = 1'b0;
      #1 check_reset_outputs("t6_async");
      sb.delete();
      repeat (2) @(negedge clk_i);
      #1 check_reset_outputs("t6_held");
      rst_ni = 1'b1;
      we_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i); #1;
         if (sram_we_o) we_cnt++;
      end
      check("t6_no_drain", 32'(we_cnt), 0);
      check("t6_mem20", mem[20], init_val(20));
      check("t6_mem21", mem[21], init_val(21));

      // Recovery after reset: one SRAM read of the in-order write
      rd_txn("post", 1'b1, 5'd10, 1'b0, 5'd0, 2, 1);
      check("sb_empty", 32'(sb.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
